// File: rtl/jstk_poll_ctrl.sv
// PmodJSTK poll sequencer: times SPI transactions, guards them with a timeout and
// decodes each 40-bit reply into position, buttons and debounced direction events.
module jstk_poll_ctrl #(
    parameter int unsigned POLL_CYCLES    = 20_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000,
    parameter logic [9:0]  DEAD_LO        = 10'd300,
    parameter logic [9:0]  DEAD_HI        = 10'd724,
    parameter int unsigned REPEAT_POLLS   = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [1:0]  led_i,
    output logic        spi_start_o,
    output logic [7:0]  spi_din_o,
    input  logic        spi_done_i,
    input  logic [39:0] spi_dout_i,
    output logic [9:0]  pos_x_o,
    output logic [9:0]  pos_y_o,
    output logic [2:0]  btn_o,
    output logic [2:0]  btn_press_o,
    output logic [3:0]  dir_evt_o,
    output logic        data_valid_o,
    output logic        timeout_o,
    output logic [1:0]  state_o
);

    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_POLLS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        Z_CENTER = 2'd0,
        Z_LOW    = 2'd1,
        Z_HIGH   = 2'd2
    } zone_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic [TW-1:0]   to_q, to_d;
    logic [7:0]      spi_din_q, spi_din_d;
    logic            start_q, start_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;
    logic [9:0]      pos_x_q, pos_x_d;
    logic [9:0]      pos_y_q, pos_y_d;
    logic [2:0]      btn_q, btn_d;
    logic [2:0]      press_q, press_d;
    logic [3:0]      dir_q, dir_d;
    zone_t           zone_x_q, zone_x_d;
    zone_t           zone_y_q, zone_y_d;
    logic [RW-1:0]   rpt_x_q, rpt_x_d;
    logic [RW-1:0]   rpt_y_q, rpt_y_d;

    logic [9:0]      new_x, new_y;
    logic [2:0]      new_btn;
    zone_t           new_zx, new_zy;
    logic            pulse_x, pulse_y;
    logic [RW-1:0]   rpt_x_nxt, rpt_y_nxt;
    logic            unused_dout_bits;

    assign new_x   = {spi_dout_i[25:24], spi_dout_i[39:32]};
    assign new_y   = {spi_dout_i[9:8], spi_dout_i[23:16]};
    assign new_btn = spi_dout_i[2:0];
    assign unused_dout_bits = ^{spi_dout_i[31:26], spi_dout_i[15:10], spi_dout_i[7:3]};

    function automatic zone_t zone_of(input logic [9:0] v);
        if (v < DEAD_LO) begin
            return Z_LOW;
        end
        if (v > DEAD_HI) begin
            return Z_HIGH;
        end
        return Z_CENTER;
    endfunction

    // A fresh excursion fires at once; holding the same side fires every REPEAT_POLLS polls.
    function automatic void axis_step(input zone_t z_new, input zone_t z_old,
                                      input logic [RW-1:0] cnt,
                                      output logic pulse, output logic [RW-1:0] cnt_n);
        pulse = 1'b0;
        cnt_n = '0;
        if (z_new != Z_CENTER) begin
            if (z_new != z_old) begin
                pulse = 1'b1;
            end else if (cnt + RW'(1) == RW'(REPEAT_POLLS)) begin
                pulse = 1'b1;
            end else begin
                cnt_n = cnt + RW'(1);
            end
        end
    endfunction

    assign new_zx = zone_of(new_x);
    assign new_zy = zone_of(new_y);

    always_comb begin
        state_d   = state_q;
        poll_d    = (poll_q != '0) ? poll_q - PW'(1) : '0;
        to_d      = (to_q != '0) ? to_q - TW'(1) : '0;
        spi_din_d = spi_din_q;
        start_d   = 1'b0;
        valid_d   = 1'b0;
        press_d   = '0;
        dir_d     = '0;
        timeout_d = timeout_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        btn_d     = btn_q;
        zone_x_d  = zone_x_q;
        zone_y_d  = zone_y_q;
        rpt_x_d   = rpt_x_q;
        rpt_y_d   = rpt_y_q;
        axis_step(new_zx, zone_x_q, rpt_x_q, pulse_x, rpt_x_nxt);
        axis_step(new_zy, zone_y_q, rpt_y_q, pulse_y, rpt_y_nxt);

        case (state_q)
            S_IDLE: begin
                // Timers are loaded on entry so START already holds the full period.
                if (enable_i && poll_q == '0) begin
                    state_d   = S_START;
                    start_d   = 1'b1;
                    spi_din_d = {6'b100000, led_i};
                    poll_d    = PW'(POLL_CYCLES - 1);
                    to_d      = TW'(TIMEOUT_CYCLES - 1);
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (spi_done_i) begin
                    state_d   = S_LATCH;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    pos_x_d   = new_x;
                    pos_y_d   = new_y;
                    btn_d     = new_btn;
                    press_d   = new_btn & ~btn_q;
                    zone_x_d  = new_zx;
                    zone_y_d  = new_zy;
                    rpt_x_d   = rpt_x_nxt;
                    rpt_y_d   = rpt_y_nxt;
                    dir_d     = {pulse_y && (new_zy == Z_HIGH), pulse_y && (new_zy == Z_LOW),
                                 pulse_x && (new_zx == Z_HIGH), pulse_x && (new_zx == Z_LOW)};
                end else if (to_q == '0) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            S_LATCH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            poll_q    <= '0;
            to_q      <= '0;
            spi_din_q <= 8'h80;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            btn_q     <= '0;
            press_q   <= '0;
            dir_q     <= '0;
            zone_x_q  <= Z_CENTER;
            zone_y_q  <= Z_CENTER;
            rpt_x_q   <= '0;
            rpt_y_q   <= '0;
        end else begin
            state_q   <= state_d;
            poll_q    <= poll_d;
            to_q      <= to_d;
            spi_din_q <= spi_din_d;
            start_q   <= start_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            dir_q     <= dir_d;
            zone_x_q  <= zone_x_d;
            zone_y_q  <= zone_y_d;
            rpt_x_q   <= rpt_x_d;
            rpt_y_q   <= rpt_y_d;
        end
    end

    assign spi_start_o  = start_q;
    assign spi_din_o    = spi_din_q;
    assign pos_x_o      = pos_x_q;
    assign pos_y_o      = pos_y_q;
    assign btn_o        = btn_q;
    assign btn_press_o  = press_q;
    assign dir_evt_o    = dir_q;
    assign data_valid_o = valid_q;
    assign timeout_o    = timeout_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// Bench for jstk_poll_ctrl: directed vector table, corner sequences and random polls
// checked against a run-length zone model.
module tb_jstk_poll_ctrl;

    localparam int POLL = 100;
    localparam int TMO  = 20;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [1:0]  led_i;
    logic        spi_start_o;
    logic [7:0]  spi_din_o;
    logic        spi_done_i;
    logic [39:0] spi_dout_i;
    logic [9:0]  pos_x_o, pos_y_o;
    logic [2:0]  btn_o, btn_press_o;
    logic [3:0]  dir_evt_o;
    logic        data_valid_o, timeout_o;
    logic [1:0]  state_o;

    jstk_poll_ctrl #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .led_i(led_i),
        .spi_start_o(spi_start_o), .spi_din_o(spi_din_o),
        .spi_done_i(spi_done_i), .spi_dout_i(spi_dout_i),
        .pos_x_o(pos_x_o), .pos_y_o(pos_y_o), .btn_o(btn_o), .btn_press_o(btn_press_o),
        .dir_evt_o(dir_evt_o), .data_valid_o(data_valid_o), .timeout_o(timeout_o),
        .state_o(state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;
    int cyc = 0;
    always @(posedge clk_i) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: zone histories of good polls, run-length based repeat rule
    int         xz_hist[$];
    int         yz_hist[$];
    logic [2:0] btn_prev;
    logic [9:0] last_x, last_y;
    logic [2:0] last_b;
    logic       exp_timeout;

    function automatic int zone(input int v);
        if (v < 300) return 1;
        if (v > 724) return 2;
        return 0;
    endfunction

    function automatic bit run_pulse(input bit is_y);
        int n, z, k;
        n = is_y ? yz_hist.size() : xz_hist.size();
        z = is_y ? yz_hist[n-1] : xz_hist[n-1];
        if (z == 0) return 1'b0;
        k = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if ((is_y ? yz_hist[i] : xz_hist[i]) != z) break;
            k++;
        end
        return ((k - 1) % 3) == 0;
    endfunction

    task automatic model_reset();
        xz_hist.delete();
        yz_hist.delete();
        btn_prev    = 3'b000;
        last_x      = '0;
        last_y      = '0;
        last_b      = '0;
        exp_timeout = 1'b0;
    endtask

    task automatic model_good(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                              output logic [3:0] e_dir, output logic [2:0] e_press);
        int zx, zy;
        bit px, py;
        zx = zone(int'(x));
        zy = zone(int'(y));
        xz_hist.push_back(zx);
        yz_hist.push_back(zy);
        px = run_pulse(1'b0);
        py = run_pulse(1'b1);
        e_dir   = {py && zy == 2, py && zy == 1, px && zx == 2, px && zx == 1};
        e_press = b & ~btn_prev;
        btn_prev    = b;
        last_x      = x;
        last_y      = y;
        last_b      = b;
        exp_timeout = 1'b0;
    endtask

    function automatic logic [39:0] make_dout(input logic [9:0] x, input logic [9:0] y,
                                              input logic [2:0] b);
        logic [39:0] d;
        d = {8'($urandom), 32'($urandom)};
        d[39:32] = x[7:0];
        d[25:24] = x[9:8];
        d[23:16] = y[7:0];
        d[9:8]   = y[9:8];
        d[2:0]   = b;
        return d;
    endfunction

    // driver tasks
    int         prev_start = -1;
    logic [1:0] led_at_start;

    task automatic wait_start();
        int n;
        n = 0;
        while (spi_start_o !== 1'b1 && n < 3 * POLL) begin
            @(negedge clk_i);
            n++;
        end
        n_checks++;
        if (spi_start_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_wait: got no spi_start expected one within %0d cycles", 3 * POLL);
        end else if (prev_start >= 0) begin
            check("start_spacing", 64'(cyc - prev_start), 64'(POLL));
        end
        prev_start   = cyc;
        led_at_start = led_i;
        check("spi_din_at_start", spi_din_o, {6'b100000, led_at_start});
    endtask

    task automatic finish_good(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                               input int dly, input bit use_tbl,
                               input logic [3:0] t_dir, input logic [2:0] t_press);
        logic [3:0] e_dir;
        logic [2:0] e_press;
        repeat (dly) @(negedge clk_i);
        check("spi_din_held", spi_din_o, {6'b100000, led_at_start});
        check("timeout_sticky", timeout_o, exp_timeout);
        spi_done_i = 1'b1;
        spi_dout_i = make_dout(x, y, b);
        model_good(x, y, b, e_dir, e_press);
        if (use_tbl) begin
            e_dir   = t_dir;
            e_press = t_press;
        end
        @(negedge clk_i);
        spi_done_i = 1'b0;
        spi_dout_i = {8'($urandom), 32'($urandom)};
        check("data_valid", data_valid_o, 1'b1);
        check("pos_x", pos_x_o, x);
        check("pos_y", pos_y_o, y);
        check("btn", btn_o, b);
        check("dir_evt", dir_evt_o, e_dir);
        check("btn_press", btn_press_o, e_press);
        check("timeout_clear", timeout_o, 1'b0);
        @(negedge clk_i);
        check("pulses_one_clk", {data_valid_o, dir_evt_o, btn_press_o}, 8'h00);
    endtask

    task automatic poll_good(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                             input int dly, input bit use_tbl,
                             input logic [3:0] t_dir, input logic [2:0] t_press);
        wait_start();
        finish_good(x, y, b, dly, use_tbl, t_dir, t_press);
    endtask

    task automatic poll_timeout();
        wait_start();
        repeat (TMO - 1) @(negedge clk_i);
        check("timeout_not_early", timeout_o, exp_timeout);
        @(negedge clk_i);
        check("timeout_set", timeout_o, 1'b1);
        check("timeout_no_valid", data_valid_o, 1'b0);
        check("timeout_state_idle", state_o, 2'd0);
        check("timeout_pos_x_kept", pos_x_o, last_x);
        check("timeout_pos_y_kept", pos_y_o, last_y);
        check("timeout_btn_kept", btn_o, last_b);
        exp_timeout = 1'b1;
        // a late reply after the abort must be ignored
        spi_done_i = 1'b1;
        spi_dout_i = make_dout(10'd1000, 10'd5, 3'b111);
        @(negedge clk_i);
        spi_done_i = 1'b0;
        check("late_done_no_valid", data_valid_o, 1'b0);
        check("late_done_pos_x", pos_x_o, last_x);
    endtask

    function automatic logic [9:0] pick(input logic [9:0] prev);
        logic [9:0] edges [6];
        edges = '{10'd299, 10'd300, 10'd301, 10'd723, 10'd724, 10'd725};
        case ($urandom_range(0, 5))
            0, 1, 2: return prev;
            3:       return 10'($urandom_range(0, 1023));
            default: return edges[$urandom_range(0, 5)];
        endcase
    endfunction

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] b;
        int         dly;
        logic [3:0] dir;
        logic [2:0] press;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [9:0] rx, ry;
        logic [2:0] rb;
        int         starts;

        // dir = {up, down, right, left}
        tbl[0]  = '{10'h3FF, 10'd512, 3'b000, 10, 4'b0010, 3'b000};
        tbl[1]  = '{10'h3FF, 10'd512, 3'b000, 10, 4'b0000, 3'b000};
        tbl[2]  = '{10'h3FF, 10'd512, 3'b000, 1,  4'b0000, 3'b000};
        tbl[3]  = '{10'h3FF, 10'd512, 3'b000, 10, 4'b0010, 3'b000};
        tbl[4]  = '{10'h3FF, 10'd512, 3'b000, 10, 4'b0000, 3'b000};
        tbl[5]  = '{10'h3FF, 10'd512, 3'b000, 10, 4'b0000, 3'b000};
        tbl[6]  = '{10'h3FF, 10'd512, 3'b000, 10, 4'b0010, 3'b000};
        tbl[7]  = '{10'd300, 10'd512, 3'b000, 10, 4'b0000, 3'b000};
        tbl[8]  = '{10'd299, 10'd512, 3'b000, 10, 4'b0001, 3'b000};
        tbl[9]  = '{10'd900, 10'd512, 3'b000, 10, 4'b0010, 3'b000};
        tbl[10] = '{10'd512, 10'd512, 3'b000, 10, 4'b0000, 3'b000};
        tbl[11] = '{10'd512, 10'd512, 3'b101, 10, 4'b0000, 3'b101};
        tbl[12] = '{10'd512, 10'd512, 3'b101, 19, 4'b0000, 3'b000};
        tbl[13] = '{10'd512, 10'd512, 3'b111, 10, 4'b0000, 3'b010};
        tbl[14] = '{10'd512, 10'd100, 3'b111, 10, 4'b0100, 3'b000};
        tbl[15] = '{10'd725, 10'd724, 3'b111, 10, 4'b0010, 3'b000};
        tbl[16] = '{10'd0,   10'h3FF, 3'b111, 10, 4'b1001, 3'b000};

        rst_i      = 1'b1;
        enable_i   = 1'b1;
        led_i      = 2'b10;
        spi_done_i = 1'b0;
        spi_dout_i = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check("rst_state", state_o, 2'd0);
        check("rst_spi_start", spi_start_o, 1'b0);
        check("rst_spi_din", spi_din_o, 8'h80);
        check("rst_outputs", {pos_x_o, pos_y_o, btn_o, btn_press_o, dir_evt_o, data_valid_o, timeout_o},
              36'h0);

        rst_i = 1'b0;
        @(negedge clk_i);
        check("first_start", spi_start_o, 1'b1);

        for (int i = 0; i < 17; i++) begin
            poll_good(tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].dly, 1'b1, tbl[i].dir, tbl[i].press);
        end

        // timeout path, then recovery with a good poll
        poll_timeout();
        poll_good(10'd600, 10'd400, 3'b001, 10, 1'b0, 4'b0000, 3'b000);

        // enable dropped mid-transaction: the transaction still completes, then no new starts
        wait_start();
        enable_i = 1'b0;
        finish_good(10'd800, 10'd200, 3'b000, 7, 1'b0, 4'b0000, 3'b000);
        starts = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk_i);
            if (spi_start_o === 1'b1) starts++;
        end
        check("no_start_when_disabled", starts, 0);
        enable_i = 1'b1;
        @(negedge clk_i);
        check("start_after_enable", spi_start_o, 1'b1);
        prev_start = -1;
        poll_good(10'd800, 10'd200, 3'b010, 12, 1'b0, 4'b0000, 3'b000);

        // random polls with occasional timeouts
        rx = 10'd512;
        ry = 10'd512;
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                poll_timeout();
            end else begin
                rx = pick(rx);
                ry = pick(ry);
                rb = 3'($urandom_range(0, 7));
                poll_good(rx, ry, rb, $urandom_range(1, 19), 1'b0, 4'b0000, 3'b000);
            end
            led_i = 2'($urandom_range(0, 3));
        end

        // reset in the middle of WAIT after a timeout left the sticky flag set
        poll_timeout();
        wait_start();
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("midwait_rst_state", state_o, 2'd0);
        check("midwait_rst_spi_din", spi_din_o, 8'h80);
        check("midwait_rst_outputs",
              {spi_start_o, pos_x_o, pos_y_o, btn_o, btn_press_o, dir_evt_o, data_valid_o, timeout_o},
              37'h0);
        model_reset();
        repeat (2) @(negedge clk_i);
        check("rst_held_no_start", spi_start_o, 1'b0);
        rst_i      = 1'b0;
        spi_done_i = 1'b1;
        spi_dout_i = make_dout(10'd1000, 10'd1000, 3'b111);
        @(negedge clk_i);
        spi_done_i = 1'b0;
        check("start_after_release", spi_start_o, 1'b1);
        check("late_done_after_rst", data_valid_o, 1'b0);
        check("pos_x_after_rst", pos_x_o, 10'd0);
        prev_start = -1;
        poll_good(10'd1000, 10'd20, 3'b011, 10, 1'b0, 4'b0000, 3'b000);
        poll_good(10'd1000, 10'd20, 3'b011, 15, 1'b0, 4'b0000, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
